// File: rtl/addsub_multicycle.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are processed DIGIT bits per
// clock on one shared adder slice, with valid/ready handshakes on both sides.
module addsub_multicycle #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gParamCheck
    $error("addsub_multicycle: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             lastSlice;
  int               sliceBase;
  logic [DIGIT-1:0] sliceA, sliceB, sliceSum;
  logic             sliceCarry;
  logic [WIDTH-1:0] sumLow;

  assign accept    = in_valid && in_ready;
  assign lastSlice = (cnt_q == CW'(N - 1));

  // The shared slice adder; sumLow is the low result with the current digit merged in,
  // so the final flags can see the last slice on the same edge it is written.
  always_comb begin
    sliceBase = int'(cnt_q) * DIGIT;
    sliceA    = opA_q[sliceBase +: DIGIT];
    sliceB    = opB_q[sliceBase +: DIGIT];
    {sliceCarry, sliceSum} = {1'b0, sliceA} + {1'b0, sliceB} + {{DIGIT{1'b0}}, carry_q};
    sumLow    = sum_q[WIDTH-1:0];
    sumLow[sliceBase +: DIGIT] = sliceSum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (lastSlice) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready must fall as soon as rst rises, so it is gated directly by rst.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      CALC: busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
    if (rst) in_ready = 1'b0;
  end

  always_comb begin
    opA_d   = opA_q;
    opB_d   = opB_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (accept) begin
      opA_d   = a;
      opB_d   = b ^ {WIDTH{sub}};
      sub_d   = sub;
      carry_d = sub;
      cnt_d   = '0;
    end else if (state_q == CALC) begin
      sum_d[WIDTH-1:0] = sumLow;
      carry_d          = sliceCarry;
      cnt_d            = cnt_q + 1'b1;
      if (lastSlice) begin
        sum_d[WIDTH] = sliceCarry ^ sub_q;
        ovf_d        = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) && (sumLow[WIDTH-1] != opA_q[WIDTH-1]);
        zero_d       = ~|sumLow;
        cnt_d        = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opA_q   <= '0;
      opB_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum  = sum_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Bench for addsub_multicycle: directed vectors and corner sequences at 16/4, plus
// randomized runs at 8/8, 32/1 and 16/4 against an integer-arithmetic reference.
module tb_addsub_multicycle;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic        subIn;
  logic [15:0] aIn, bIn;
  logic        outValid;
  logic        outReady;
  logic [16:0] sumOut;
  logic        ovfOut, zeroOut, busyOut;

  int checks   = 0;
  int failures = 0;

  addsub_multicycle #(.WIDTH(16), .DIGIT(4)) uDut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .sub(subIn),
    .a(aIn), .b(bIn), .out_valid(outValid), .out_ready(outReady),
    .sum(sumOut), .ovf(ovfOut), .zero(zeroOut), .busy(busyOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one op at the next negedge, then counts edges until out_valid.
  task automatic applyStimulus(input logic s, input logic [15:0] x, input logic [15:0] y, output int lat);
    @(negedge clk);
    inValid = 1'b1;
    subIn   = s;
    aIn     = x;
    bIn     = y;
    #1;
    checkOutput("in_ready_before_accept", inReady, 1);
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    outReady = 1'b0;
    subIn    = 1'($urandom);
    aIn      = 16'($urandom);
    bIn      = 16'($urandom);
    lat      = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1 || 1'b1) begin
        @(posedge clk);
        #1;
        if (outValid) begin
          lat = i;
          break;
        end
      end
    end
  endtask

  task automatic releaseResult();
    @(negedge clk);
    outReady = 1'b1;
    inValid  = 1'b0;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput("release_to_idle", outValid, 0);
  endtask

  typedef struct {
    string       name;
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] expSum;
    logic        expOvf;
    logic        expZero;
  } vec_t;

  function automatic vec_t mkVec(input string n, input logic s, input logic [15:0] x,
                                 input logic [15:0] y, input logic [16:0] es,
                                 input logic eo, input logic ez);
    vec_t v;
    v.name = n; v.s = s; v.a = x; v.b = y;
    v.expSum = es; v.expOvf = eo; v.expZero = ez;
    return v;
  endfunction

  // Randomized runs, one independent DUT per configuration.
  for (genvar g = 0; g < 3; g++) begin : gRand
    localparam int W   = (g == 0) ? 8 : (g == 1) ? 32 : 16;
    localparam int D   = (g == 0) ? 8 : (g == 1) ? 1 : 4;
    localparam int N   = W / D;
    localparam int OPS = (g == 2) ? 300 : 1000;

    logic         rRst, rInValid, rInReady, rSub, rOutValid, rOutReady, rOvf, rZero, rBusy;
    logic [W-1:0] rA, rB;
    logic [W:0]   rSum;
    bit           done;

    addsub_multicycle #(.WIDTH(W), .DIGIT(D)) uRand (
      .clk(clk), .rst(rRst), .in_valid(rInValid), .in_ready(rInReady), .sub(rSub),
      .a(rA), .b(rB), .out_valid(rOutValid), .out_ready(rOutReady),
      .sum(rSum), .ovf(rOvf), .zero(rZero), .busy(rBusy)
    );

    typedef struct {
      logic [W:0] sum;
      logic       ovf;
      logic       zero;
      int         acceptEdge;
    } exp_t;

    exp_t expQ[$];

    function automatic exp_t refModel(input logic s, input logic [W-1:0] x,
                                      input logic [W-1:0] y, input int e);
      exp_t   m;
      longint ux, uy, sx, sy, ur, sr, smax, smin;
      ux   = longint'(x);
      uy   = longint'(y);
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      ur   = s ? ux - uy : ux + uy;
      sr   = s ? sx - sy : sx + sy;
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -smax - 1;
      m.sum        = ur[W:0];
      m.ovf        = (sr > smax) || (sr < smin);
      m.zero       = (ur[W-1:0] == '0);
      m.acceptEdge = e;
      return m;
    endfunction

    initial begin : randTest
      int           cyc, opsIssued, opsDone;
      bit           haveOp, seen, aborted;
      logic         pSub;
      logic [W-1:0] pA, pB;
      exp_t         m;
      cyc = 0; opsIssued = 0; opsDone = 0;
      haveOp = 0; seen = 0; aborted = 0;
      pSub = 0; pA = '0; pB = '0;
      done = 0;
      rRst = 1'b1; rInValid = 1'b0; rOutReady = 1'b0; rSub = 1'b0; rA = '0; rB = '0;
      repeat (2) @(negedge clk);
      rRst = 1'b0;
      while (opsDone < OPS && cyc < 90000 && !aborted) begin
        @(negedge clk);
        if (!haveOp && opsIssued < OPS) begin
          pSub   = 1'($urandom);
          pA     = W'($urandom);
          pB     = W'($urandom);
          haveOp = 1;
        end
        rInValid  = haveOp && ($urandom_range(0, 3) != 0);
        rSub      = rInValid ? pSub : 1'($urandom);
        rA        = rInValid ? pA : W'($urandom);
        rB        = rInValid ? pB : W'($urandom);
        rOutReady = 1'($urandom);
        #1;
        if (expQ.size() == 0) begin
          checkOutput("rand_idle_valid", rOutValid, 0);
        end else if (!seen) begin
          if (rOutValid) begin
            seen = 1;
            checkOutput("rand_latency", cyc - expQ[0].acceptEdge, N);
          end else if (cyc - expQ[0].acceptEdge > N) begin
            checkOutput("rand_timeout", rOutValid, 1);
            aborted = 1;
          end
        end
        checkOutput("rand_in_ready", rInReady,
                    (expQ.size() == 0) || (rOutValid && rOutReady));
        if (rOutValid && rOutReady && expQ.size() > 0) begin
          m = expQ.pop_front();
          checkOutput("rand_sum", rSum, m.sum);
          checkOutput("rand_ovf", rOvf, m.ovf);
          checkOutput("rand_zero", rZero, m.zero);
          seen = 0;
          opsDone++;
        end
        if (rInValid && rInReady) begin
          expQ.push_back(refModel(pSub, pA, pB, cyc + 1));
          haveOp = 0;
          opsIssued++;
        end
        @(posedge clk);
        cyc++;
      end
      checkOutput("rand_ops_completed", opsDone, OPS);
      done = 1;
    end
  end

  initial begin : directed
    vec_t vecs[10];
    int   lat;
    bit   sawValid;
    logic [16:0] held;

    vecs[0] = mkVec("add_ffff_0001", 0, 16'hFFFF, 16'h0001, 17'h10000, 0, 1);
    vecs[1] = mkVec("sub_0005_0007", 1, 16'h0005, 16'h0007, 17'h1FFFE, 0, 0);
    vecs[2] = mkVec("add_7fff_0001", 0, 16'h7FFF, 16'h0001, 17'h08000, 1, 0);
    vecs[3] = mkVec("sub_8000_0001", 1, 16'h8000, 16'h0001, 17'h07FFF, 1, 0);
    vecs[4] = mkVec("add_1234_1111", 0, 16'h1234, 16'h1111, 17'h02345, 0, 0);
    vecs[5] = mkVec("add_8000_8000", 0, 16'h8000, 16'h8000, 17'h10000, 1, 1);
    vecs[6] = mkVec("sub_0000_0001", 1, 16'h0000, 16'h0001, 17'h1FFFF, 0, 0);
    vecs[7] = mkVec("sub_7fff_ffff", 1, 16'h7FFF, 16'hFFFF, 17'h18000, 1, 0);
    vecs[8] = mkVec("sub_1234_1234", 1, 16'h1234, 16'h1234, 17'h00000, 0, 1);
    vecs[9] = mkVec("add_0000_0000", 0, 16'h0000, 16'h0000, 17'h00000, 0, 1);

    rst = 1'b1; inValid = 1'b0; outReady = 1'b0; subIn = 1'b0; aIn = '0; bIn = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_busy", busyOut, 0);
    checkOutput("reset_sum", sumOut, 0);
    checkOutput("reset_flags", {ovfOut, zeroOut}, 0);
    checkOutput("reset_in_ready", inReady, 0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", inReady, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].b, lat);
      checkOutput({vecs[i].name, "_latency"}, lat, 4);
      checkOutput({vecs[i].name, "_sum"}, sumOut, vecs[i].expSum);
      checkOutput({vecs[i].name, "_ovf"}, ovfOut, vecs[i].expOvf);
      checkOutput({vecs[i].name, "_zero"}, zeroOut, vecs[i].expZero);
      releaseResult();
    end

    // Stall the consumer, then accept a new op on the very edge the result leaves.
    applyStimulus(0, 16'h00AA, 16'h0055, lat);
    checkOutput("stall_first_sum", sumOut, 17'h000FF);
    held = sumOut;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("stall_sum_stable", sumOut, held);
      checkOutput("stall_out_valid", outValid, 1);
      checkOutput("stall_in_ready", inReady, 0);
    end
    outReady = 1'b1;
    applyStimulus(0, 16'h0001, 16'h0002, lat);
    checkOutput("b2b_latency", lat, 4);
    checkOutput("b2b_sum", sumOut, 17'h00003);
    releaseResult();

    // Reset during the second CALC cycle discards the in-flight op.
    @(negedge clk);
    inValid = 1'b1; subIn = 1'b0; aIn = 16'h4321; bIn = 16'h1111;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("midcalc_busy", busyOut, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midcalc_rst_out_valid", outValid, 0);
    checkOutput("midcalc_rst_busy", busyOut, 0);
    checkOutput("midcalc_rst_sum", sumOut, 0);
    checkOutput("midcalc_rst_in_ready", inReady, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sawValid = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (outValid) sawValid = 1;
    end
    checkOutput("midcalc_no_result", sawValid, 0);
    applyStimulus(0, 16'h1234, 16'h1111, lat);
    checkOutput("after_rst_latency", lat, 4);
    checkOutput("after_rst_sum", sumOut, 17'h02345);
    releaseResult();

    for (int i = 0; i < 100000; i++) begin
      if (gRand[0].done && gRand[1].done && gRand[2].done) break;
      @(posedge clk);
    end
    checkOutput("rand_runs_finished", {gRand[2].done, gRand[1].done, gRand[0].done}, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
